// File: rtl/fp_mul_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined fp_mul between NUM_REQ requesters,
// with a tag pipe routing each result back to its issuer. Optional MUL_ARB_STATS_EN adds counters.
module fp_mul_rr_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REQ     = 2,
    parameter int MUL_LATENCY = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dataa,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_datab,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          mul_aclr,
    output logic                          mul_clk_en,
    output logic [DATA_WIDTH-1:0]         mul_dataa,
    output logic [DATA_WIDTH-1:0]         mul_datab,
    input  logic [DATA_WIDTH-1:0]         mul_result,
`ifdef MUL_ARB_STATS_EN
    output logic [31:0]                   issue_count,
    output logic [31:0]                   conflict_count,
`endif
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int LAST  = MUL_LATENCY;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    run_s;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        gidx_s;
    logic                    grant_any_s;
    logic                    found_s;
    logic                    clk_en_s;
    logic [DATA_WIDTH-1:0]   mul_dataa_q, mul_dataa_d;
    logic [DATA_WIDTH-1:0]   mul_datab_q, mul_datab_d;
    logic [LAST:0]           vld_q, vld_d;
    logic [IDX_W-1:0]        idx_q [LAST+1];
    logic [IDX_W-1:0]        idx_d [LAST+1];

    // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        grant   = '0;
        gidx_s  = '0;
        found_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int cand;
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end else begin
                cand = cand;
            end
            if (!found_s && !rst && req[cand]) begin
                found_s     = 1'b1;
                grant[cand] = 1'b1;
                gidx_s      = IDX_W'(cand);
            end else begin
                found_s = found_s;
            end
        end
        grant_any_s = found_s;
    end

    // A valid tag can only exist in RUN, so gating it with run_s keeps clk_en = grant | any tag valid.
    always_comb begin
        if (rst) begin
            clk_en_s = 1'b0;
        end else begin
            clk_en_s = grant_any_s | (run_s & (|vld_q));
        end
    end

    // Pointer, operand register and tag pipe next-state.
    always_comb begin
        ptr_d       = ptr_q;
        mul_dataa_d = mul_dataa_q;
        mul_datab_d = mul_datab_q;
        vld_d       = vld_q;
        idx_d       = idx_q;
        if (grant_any_s) begin
            mul_dataa_d = req_dataa[gidx_s*DATA_WIDTH +: DATA_WIDTH];
            mul_datab_d = req_datab[gidx_s*DATA_WIDTH +: DATA_WIDTH];
            if (gidx_s == IDX_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gidx_s + IDX_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
        if (clk_en_s) begin
            vld_d    = {vld_q[LAST-1:0], grant_any_s};
            idx_d[0] = gidx_s;
            for (int k = 1; k <= LAST; k++) begin
                idx_d[k] = idx_q[k-1];
            end
        end else begin
            vld_d = vld_q;
        end
    end

    // Datapath and tag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            mul_dataa_q <= '0;
            mul_datab_q <= '0;
            vld_q       <= '0;
            for (int k = 0; k <= LAST; k++) begin
                idx_q[k] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            mul_dataa_q <= mul_dataa_d;
            mul_datab_q <= mul_datab_d;
            vld_q       <= vld_d;
            for (int k = 0; k <= LAST; k++) begin
                idx_q[k] <= idx_d[k];
            end
        end
    end

    // Status FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Status FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any_s) state_d = ST_RUN;
                else             state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (!grant_any_s && !(|vld_q)) state_d = ST_IDLE;
                else                           state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status FSM outputs.
    always_comb begin
        run_s = 1'b0;
        case (state_q)
            ST_IDLE: run_s = 1'b0;
            ST_RUN:  run_s = 1'b1;
            default: run_s = 1'b0;
        endcase
    end

    // Result routing from the last tag stage.
    always_comb begin
        if (!rst && vld_q[LAST]) begin
            resp_valid = NUM_REQ'(1) << idx_q[LAST];
        end else begin
            resp_valid = '0;
        end
    end

    assign mul_aclr   = rst;
    assign mul_clk_en = clk_en_s;
    assign mul_dataa  = mul_dataa_q;
    assign mul_datab  = mul_datab_q;
    assign resp_data  = mul_result;

`ifdef MUL_ARB_STATS_EN
    logic [31:0] issue_count_q, issue_count_d;
    logic [31:0] conflict_count_q, conflict_count_d;

    // Saturating usage counters.
    always_comb begin
        issue_count_d    = issue_count_q;
        conflict_count_d = conflict_count_q;
        if (grant_any_s && (issue_count_q != 32'hFFFF_FFFF)) begin
            issue_count_d = issue_count_q + 32'd1;
        end else begin
            issue_count_d = issue_count_q;
        end
        if ((32'($countones(req)) >= 32'd2) && (conflict_count_q != 32'hFFFF_FFFF)) begin
            conflict_count_d = conflict_count_q + 32'd1;
        end else begin
            conflict_count_d = conflict_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_count_q    <= '0;
            conflict_count_q <= '0;
        end else begin
            issue_count_q    <= issue_count_d;
            conflict_count_q <= conflict_count_d;
        end
    end

    assign issue_count    = issue_count_q;
    assign conflict_count = conflict_count_q;
`endif

endmodule

// File: tb/tb_fp_mul_rr_arbiter.sv
// Directed bench for fp_mul_rr_arbiter; a table-driven stand-in models the 11-stage fp_mul.
module tb_fp_mul_rr_arbiter;

    localparam int DW = 32;
    localparam int NR = 2;
    localparam int ML = 11;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] req_dataa;
    logic [NR*DW-1:0] req_datab;
    logic [NR-1:0]   grant;
    logic            mul_aclr;
    logic            mul_clk_en;
    logic [DW-1:0]   mul_dataa;
    logic [DW-1:0]   mul_datab;
    logic [DW-1:0]   mul_result;
    logic [NR-1:0]   resp_valid;
    logic [DW-1:0]   resp_data;
`ifdef MUL_ARB_STATS_EN
    logic [31:0]     issue_count;
    logic [31:0]     conflict_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    fp_mul_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MUL_LATENCY(ML)) dut (
        .clk(clk), .rst(rst), .req(req), .req_dataa(req_dataa), .req_datab(req_datab),
        .grant(grant), .mul_aclr(mul_aclr), .mul_clk_en(mul_clk_en),
        .mul_dataa(mul_dataa), .mul_datab(mul_datab), .mul_result(mul_result),
`ifdef MUL_ARB_STATS_EN
        .issue_count(issue_count), .conflict_count(conflict_count),
`endif
        .resp_valid(resp_valid), .resp_data(resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Known products for the directed operands; anything else yields a recognisable junk value.
    function automatic logic [31:0] fmul_tab(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] key;
        key = {a, b};
        case (key)
            64'h40000000_40400000: return 32'h40C00000;
            64'h3F000000_40800000: return 32'h40000000;
            64'h40400000_40400000: return 32'h41100000;
            default:               return a ^ b;
        endcase
    endfunction

    logic [DW-1:0] mpipe [ML];
    always @(posedge clk) begin
        if (mul_aclr) begin
            for (int i = 0; i < ML; i++) mpipe[i] <= '0;
        end else if (mul_clk_en) begin
            mpipe[0] <= fmul_tab(mul_dataa, mul_datab);
            for (int i = 1; i < ML; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_result = mpipe[ML-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        next();
        next();
        rst = 1'b0;
    endtask

    logic [NR-1:0] exp_rv;
    logic [31:0]   exp_rd;

    initial begin
        rst = 1'b1;
        req = '0;
        req_dataa = '0;
        req_datab = '0;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_dataa", mul_dataa, 32'h0);
        chk("rst_datab", mul_datab, 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_clk_en", 32'(mul_clk_en), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        next();

        // Single op, requester 0: 2.0 * 3.0
        req_dataa[0 +: DW] = 32'h40000000;
        req_datab[0 +: DW] = 32'h40400000;
        req = 2'b01;
        @(negedge clk);
        chk("t1_grant", 32'(grant), 32'h1);
        next();
        req = 2'b00;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            exp_rv = (c == 12) ? 2'b01 : 2'b00;
            chk($sformatf("t1_rv_c%0d", c), 32'(resp_valid), 32'(exp_rv));
            if (c == 12) chk("t1_data", resp_data, 32'h40C00000);
            if (c == 13) chk("t1_clk_en_off", 32'(mul_clk_en), 32'h0);
            next();
        end

        // Two requesters, one cycle apart
        do_reset();
        req_dataa[0 +: DW]  = 32'h3F000000;
        req_datab[0 +: DW]  = 32'h40800000;
        req_dataa[DW +: DW] = 32'h40400000;
        req_datab[DW +: DW] = 32'h40400000;
        req = 2'b11;
        @(negedge clk);
        chk("t2_grant0", 32'(grant), 32'h1);
        next();
        req = 2'b10;
        @(negedge clk);
        chk("t2_grant1", 32'(grant), 32'h2);
        next();
        req = 2'b00;
        for (int c = 2; c <= 14; c++) begin
            @(negedge clk);
            exp_rv = (c == 12) ? 2'b01 : (c == 13) ? 2'b10 : 2'b00;
            chk($sformatf("t2_rv_c%0d", c), 32'(resp_valid), 32'(exp_rv));
            if (c == 12) chk("t2_data0", resp_data, 32'h40000000);
            if (c == 13) chk("t2_data1", resp_data, 32'h41100000);
            next();
        end

        // Both held for 6 cycles: grants alternate, results follow in issue order
        do_reset();
        req_dataa[0 +: DW]  = 32'h40000000;
        req_datab[0 +: DW]  = 32'h40400000;
        req_dataa[DW +: DW] = 32'h40400000;
        req_datab[DW +: DW] = 32'h40400000;
        req = 2'b11;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("t3_grant_c%0d", c), 32'(grant), (c % 2 == 0) ? 32'h1 : 32'h2);
            next();
        end
        req = 2'b00;
        for (int c = 6; c <= 18; c++) begin
            @(negedge clk);
            if (c >= 12 && c <= 17) begin
                exp_rv = (c % 2 == 0) ? 2'b01 : 2'b10;
                exp_rd = (c % 2 == 0) ? 32'h40C00000 : 32'h41100000;
                chk($sformatf("t3_data_c%0d", c), resp_data, exp_rd);
            end else begin
                exp_rv = 2'b00;
            end
            chk($sformatf("t3_rv_c%0d", c), 32'(resp_valid), 32'(exp_rv));
            next();
        end

        // Reset mid-flight discards in-flight ops and rewinds the pointer
        do_reset();
        req = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("t4_grant_c%0d", c), 32'(grant), (c % 2 == 0) ? 32'h1 : 32'h2);
            next();
        end
        req = 2'b00;
        next();
        next();
        rst = 1'b1;
        req = 2'b11;
        @(negedge clk);
        chk("t4_grant_in_rst", 32'(grant), 32'h0);
        chk("t4_aclr", 32'(mul_aclr), 32'h1);
        next();
        rst = 1'b0;
        req = 2'b00;
        for (int c = 6; c <= 20; c++) begin
            @(negedge clk);
            chk($sformatf("t4_rv_c%0d", c), 32'(resp_valid), 32'h0);
            next();
        end
        req = 2'b11;
        @(negedge clk);
        chk("t4_ptr_rewound", 32'(grant), 32'h1);
        next();
        req = 2'b00;

        // Idle after reset
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("t5_grant_c%0d", c), 32'(grant), 32'h0);
            chk($sformatf("t5_clk_en_c%0d", c), 32'(mul_clk_en), 32'h0);
            chk($sformatf("t5_rv_c%0d", c), 32'(resp_valid), 32'h0);
            next();
        end

`ifdef MUL_ARB_STATS_EN
        do_reset();
        req = 2'b11;
        for (int c = 0; c < 4; c++) next();
        req = 2'b01;
        for (int c = 0; c < 2; c++) next();
        req = 2'b00;
        @(negedge clk);
        chk("stats_issue", issue_count, 32'd6);
        chk("stats_conflict", conflict_count, 32'd4);
        next();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
